// File: rtl/movement_controller_2d.sv
// -----------------------------------------------------------------------------
// movement_controller_2d
//   Two-axis player movement. An internal divider produces a one-clock
//   movement tick. On each tick the left/right/up/down buttons are sampled
//   and an (x, y) position is stepped inside [0..X_MAX] x [0..Y_MAX].
//   A direction that is held for HOLD_TICKS ticks switches that axis from
//   SLOW_STEP to FAST_STEP.
//
//   Optional build macro: MOVEMENT_WRAP_EN
//     undefined : position clamps at 0 / MAX (no change -> no moved pulse)
//     defined   : position wraps 0 <-> MAX (a wrap always pulses moved)
//
//   Handshake: none. Inputs are level signals sampled only on tick clocks;
//   outputs are registered levels, and moved is a one-clock pulse.
//
// Ports (movement_controller_2d):
//   clock        in   50 MHz system clock, all state on posedge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = run, 0 = freeze (divider held, no ticks)
//   left/right   in   x toward 0 / toward X_MAX
//   up/down      in   y toward 0 / toward Y_MAX
//   x_val        out  current x position (X_WIDTH bits)
//   y_val        out  current y position (Y_WIDTH bits)
//   moved        out  one-clock pulse: a position changed on the last tick
//   fast         out  high while either axis is in fast stepping
//   x_state_dbg  out  x axis FSM state (0 IDLE, 1 SLOW, 2 FAST)
//   y_state_dbg  out  y axis FSM state (0 IDLE, 1 SLOW, 2 FAST)
//
// Ports (movement_axis, one per axis):
//   clock, reset  as above
//   tick          movement tick from the divider
//   neg_btn       button toward 0
//   pos_btn       button toward MAX
//   pos_val       registered position
//   state         registered FSM state
//   fast_next     FSM state after this clock is FAST
//   change        this clock is a tick that changes the position
// -----------------------------------------------------------------------------

module movement_axis #(
  parameter int W          = 8,
  parameter int MAX        = 159,
  parameter int INIT       = 80,
  parameter int SLOW_STEP  = 1,
  parameter int FAST_STEP  = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         neg_btn,
  input  logic         pos_btn,
  output logic [W-1:0] pos_val,
  output logic [1:0]   state,
  output logic         fast_next,
  output logic         change
);

  typedef enum logic [1:0] {IDLE = 2'd0, SLOW = 2'd1, FAST = 2'd2} axis_state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_NEG = 2'd1, DIR_POS = 2'd2} dir_t;

  // Hold count never exceeds HOLD_TICKS+1, so size for that.
  localparam int HW = $clog2(HOLD_TICKS + 2);

  localparam logic [W:0]   SLOW_W = (W+1)'(SLOW_STEP);
  localparam logic [W:0]   FAST_W = (W+1)'(FAST_STEP);
  localparam logic [W:0]   MAX_W  = (W+1)'(MAX);

  // Value taken when a step would leave the playfield.
`ifdef MOVEMENT_WRAP_EN
  localparam logic [W-1:0] NEG_EDGE = W'(MAX);
  localparam logic [W-1:0] POS_EDGE = '0;
`else
  localparam logic [W-1:0] NEG_EDGE = '0;
  localparam logic [W-1:0] POS_EDGE = W'(MAX);
`endif

  axis_state_t   state_q, state_d;
  dir_t          dir_q, dir_d, dir_now;
  logic [HW-1:0] hold_q, hold_d;
  logic [W-1:0]  pos_q, pos_d;
  logic [W:0]    step, wide_pos, sum, diff;

  always_comb begin
    dir_now = DIR_NONE;
    if (neg_btn && !pos_btn)      dir_now = DIR_NEG;
    else if (pos_btn && !neg_btn) dir_now = DIR_POS;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      hold_q  <= '0;
      pos_q   <= W'(INIT);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    hold_d   = hold_q;
    pos_d    = pos_q;
    step     = SLOW_W;
    wide_pos = {1'b0, pos_q};
    sum      = '0;
    diff     = '0;
    if (tick) begin
      dir_d = dir_now;
      if (dir_now == DIR_NONE) begin
        state_d = IDLE;
        hold_d  = '0;
      end else if (dir_now != dir_q) begin
        // New or reversed direction restarts the hold count.
        state_d = (HOLD_TICKS <= 1) ? FAST : SLOW;
        hold_d  = HW'(1);
      end else if (state_q == SLOW) begin
        hold_d = hold_q + HW'(1);
        if (int'(hold_d) >= HOLD_TICKS) state_d = FAST;
      end
      // The tick that enters FAST already uses the fast step.
      step = (state_d == FAST) ? FAST_W : SLOW_W;
      sum  = wide_pos + step;
      diff = wide_pos - step;
      if (dir_now == DIR_NEG) begin
        pos_d = (wide_pos < step) ? NEG_EDGE : diff[W-1:0];
      end else if (dir_now == DIR_POS) begin
        pos_d = (sum > MAX_W) ? POS_EDGE : sum[W-1:0];
      end
    end
  end

  assign pos_val   = pos_q;
  assign state     = state_q;
  assign fast_next = (state_d == FAST);
  assign change    = tick && (pos_d != pos_q);

endmodule

module movement_controller_2d #(
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int X_INIT     = 80,
  parameter int Y_INIT     = 110,
  parameter int TICK_COUNT = 24999999,
  parameter int SLOW_STEP  = 1,
  parameter int FAST_STEP  = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  output logic [X_WIDTH-1:0] x_val,
  output logic [Y_WIDTH-1:0] y_val,
  output logic               moved,
  output logic               fast,
  output logic [1:0]         x_state_dbg,
  output logic [1:0]         y_state_dbg
);

  localparam int              CW     = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(TICK_COUNT);

  logic [CW-1:0] div_q;
  logic          tick;
  logic          x_change, y_change, x_fast_next, y_fast_next;

  assign tick = enable && (div_q == '0);

  // Divider: held at RELOAD while frozen so a re-enable always starts a
  // full tick period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= RELOAD;
    end else if (!enable || div_q == '0) begin
      div_q <= RELOAD;
    end else begin
      div_q <= div_q - CW'(1);
    end
  end

  movement_axis #(
    .W(X_WIDTH), .MAX(X_MAX), .INIT(X_INIT),
    .SLOW_STEP(SLOW_STEP), .FAST_STEP(FAST_STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_x_axis (
    .clock(clock), .reset(reset), .tick(tick),
    .neg_btn(left), .pos_btn(right),
    .pos_val(x_val), .state(x_state_dbg),
    .fast_next(x_fast_next), .change(x_change)
  );

  movement_axis #(
    .W(Y_WIDTH), .MAX(Y_MAX), .INIT(Y_INIT),
    .SLOW_STEP(SLOW_STEP), .FAST_STEP(FAST_STEP), .HOLD_TICKS(HOLD_TICKS)
  ) u_y_axis (
    .clock(clock), .reset(reset), .tick(tick),
    .neg_btn(up), .pos_btn(down),
    .pos_val(y_val), .state(y_state_dbg),
    .fast_next(y_fast_next), .change(y_change)
  );

  // moved and fast land in the same cycle as the new position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      moved <= 1'b0;
      fast  <= 1'b0;
    end else begin
      moved <= x_change || y_change;
      fast  <= x_fast_next || y_fast_next;
    end
  end

endmodule

// File: tb/tb_movement_controller_2d.sv
// -----------------------------------------------------------------------------
// tb_movement_controller_2d
//   Directed steps followed by randomized button/enable stimulus. A reference
//   model (tick phase, per-axis run length of the held direction, integer
//   position arithmetic) predicts x/y/moved/fast for every clock; predictions
//   go through an expected queue and are compared on the falling edge.
// -----------------------------------------------------------------------------

module tb_movement_controller_2d;

  localparam int X_WIDTH    = 8;
  localparam int Y_WIDTH    = 7;
  localparam int X_MAX      = 159;
  localparam int Y_MAX      = 119;
  localparam int X_INIT     = 80;
  localparam int Y_INIT     = 110;
  localparam int TICK_COUNT = 3;
  localparam int SLOW_STEP  = 1;
  localparam int FAST_STEP  = 4;
  localparam int HOLD_TICKS = 3;
  localparam int SB_W       = X_WIDTH + Y_WIDTH + 2;

`ifdef MOVEMENT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;
  logic left   = 1'b0;
  logic right  = 1'b0;
  logic up     = 1'b0;
  logic down   = 1'b0;

  logic [X_WIDTH-1:0] x_val;
  logic [Y_WIDTH-1:0] y_val;
  logic               moved;
  logic               fast;
  logic [1:0]         x_state_dbg;
  logic [1:0]         y_state_dbg;

  always #5 clock = ~clock;

  movement_controller_2d #(
    .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .TICK_COUNT(TICK_COUNT),
    .SLOW_STEP(SLOW_STEP), .FAST_STEP(FAST_STEP), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .left(left), .right(right), .up(up), .down(down),
    .x_val(x_val), .y_val(y_val), .moved(moved), .fast(fast),
    .x_state_dbg(x_state_dbg), .y_state_dbg(y_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [SB_W-1:0] got,
                           input logic [SB_W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed{x,y,moved,fast}=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x, m_y;        // positions
  int m_xdir, m_ydir;  // last sampled direction: -1, 0, +1
  int m_xrun, m_yrun;  // consecutive ticks the current direction was held
  int m_phase;         // enabled clocks since the last tick / reload
  int m_ticks = 0;
  bit m_moved, m_fast;
  string step_tag = "reset";

  task automatic model_reset();
    m_x = X_INIT;  m_y = Y_INIT;
    m_xdir = 0;    m_ydir = 0;
    m_xrun = 0;    m_yrun = 0;
    m_phase = 0;
    m_moved = 1'b0; m_fast = 1'b0;
  endtask

  task automatic axis_model(input logic nb, input logic pb, input int max,
                            inout int p, inout int d, inout int r, output bit ch);
    int dir, step, nv;
    dir = (nb && !pb) ? -1 : ((pb && !nb) ? 1 : 0);
    if (dir == 0)      r = 0;
    else if (dir == d) r = (r < HOLD_TICKS) ? r + 1 : r;
    else               r = 1;
    d    = dir;
    step = (r >= HOLD_TICKS) ? FAST_STEP : SLOW_STEP;
    nv   = p + dir * step;
    if (nv < 0)        nv = WRAP ? max : 0;
    else if (nv > max) nv = WRAP ? 0 : max;
    ch = (nv != p);
    p  = nv;
  endtask

  task automatic model_edge();
    bit tick_now, xch, ych;
    tick_now = 1'b0;
    xch = 1'b0;
    ych = 1'b0;
    if (!enable)                    m_phase = 0;
    else if (m_phase == TICK_COUNT) begin tick_now = 1'b1; m_phase = 0; end
    else                            m_phase++;
    if (tick_now) begin
      m_ticks++;
      axis_model(left, right, X_MAX, m_x, m_xdir, m_xrun, xch);
      axis_model(up,   down,  Y_MAX, m_y, m_ydir, m_yrun, ych);
    end
    m_moved = xch || ych;
    m_fast  = (m_xrun >= HOLD_TICKS) || (m_yrun >= HOLD_TICKS);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model the edge, then compare on the falling edge.
  task automatic cycle();
    logic [SB_W-1:0] exp;
    @(posedge clock);
    if (reset) model_reset();
    else       model_edge();
    exp_q.push_back({X_WIDTH'(m_x), Y_WIDTH'(m_y), m_moved, m_fast});
    @(negedge clock);
    exp = exp_q.pop_front();
    check_vec(step_tag, {x_val, y_val, moved, fast}, exp);
  endtask

  task automatic run_ticks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = 0;
    while (m_ticks < target && budget < 1000) begin
      cycle();
      budget++;
    end
    if (m_ticks < target) begin
      n_checks++;
      n_fail++;
      $error("FAIL tick_timeout observed=%0d expected=%0d", m_ticks, target);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int moved_seen;
    int x_frozen;
    logic [3:0] btn;

    model_reset();
    #2 reset = 1'b1;
    #1;
    check("reset_x", int'(x_val), X_INIT);
    check("reset_y", int'(y_val), Y_INIT);
    check("reset_moved", int'(moved), 0);
    check("reset_fast", int'(fast), 0);
    cycle();
    cycle();
    reset = 1'b0;

    // Idle: enabled, no buttons.
    step_tag = "idle";
    enable = 1'b1;
    moved_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (moved) moved_seen++;
    end
    check("idle_moved_count", moved_seen, 0);
    check("idle_x", int'(x_val), 80);
    check("idle_y", int'(y_val), 110);

    // Right held for five ticks: 81, 82, 86, 90, 94.
    step_tag = "right_hold";
    right = 1'b1;
    run_ticks(2);
    check("right_slow_fast", int'(fast), 0);
    run_ticks(1);
    check("right_tick3_x", int'(x_val), 86);
    check("right_tick3_fast", int'(fast), 1);
    run_ticks(2);
    check("right_tick5_x", int'(x_val), 94);
    check("right_tick5_moved", int'(moved), 1);

    // Reset mid-count while in FAST.
    step_tag = "midcount_reset";
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("mid_reset_x", int'(x_val), 80);
    check("mid_reset_y", int'(y_val), 110);
    check("mid_reset_fast", int'(fast), 0);
    check("mid_reset_moved", int'(moved), 0);
    cycle();
    reset = 1'b0;
    right = 1'b0;

    // Both x buttons (cancel) plus down: y 111, 112, 116, 119, then clamp.
    step_tag = "down_clamp";
    left = 1'b1; right = 1'b1; down = 1'b1;
    run_ticks(3);
    check("down_tick3_y", int'(y_val), 116);
    run_ticks(1);
    check("down_tick4_y", int'(y_val), 119);
    check("down_tick4_moved", int'(moved), 1);
    run_ticks(1);
    check("down_tick5_y", int'(y_val), 119);
    check("down_tick5_moved", int'(moved), 0);
    check("down_x_still", int'(x_val), 80);

    // Walk x down to 2, release, then left from a fresh start.
    step_tag = "left_edge";
    right = 1'b0; down = 1'b0;
    run_ticks(21);
    check("left_walk_x", int'(x_val), 2);
    left = 1'b0;
    run_ticks(1);
    check("left_release_fast", int'(fast), 0);
    left = 1'b1;
    run_ticks(1);
    check("left_edge1_x", int'(x_val), 1);
    run_ticks(1);
    check("left_edge2_x", int'(x_val), 0);
    check("left_edge2_moved", int'(moved), 1);
    run_ticks(1);
    check("left_edge3_x", int'(x_val), WRAP ? X_MAX : 0);
    check("left_edge3_moved", int'(moved), WRAP ? 1 : 0);

    // y at 119, down for one tick.
    step_tag = "down_edge";
    left = 1'b0; down = 1'b1;
    run_ticks(1);
    check("down_edge_y", int'(y_val), WRAP ? 0 : Y_MAX);
    check("down_edge_moved", int'(moved), WRAP ? 1 : 0);
    down = 1'b0;

    // Freeze while fast, then resume.
    step_tag = "freeze";
    right = 1'b1;
    run_ticks(4);
    check("freeze_pre_fast", int'(fast), 1);
    x_frozen = m_x;
    enable = 1'b0;
    repeat (10) cycle();
    check("freeze_x", int'(x_val), x_frozen);
    check("freeze_fast", int'(fast), 1);
    enable = 1'b1;
    repeat (TICK_COUNT) cycle();
    check("resume_early_x", int'(x_val), x_frozen);
    cycle();
    check("resume_x", int'(x_val), x_frozen + FAST_STEP);
    check("resume_moved", int'(moved), 1);

    // Randomized buttons and enable.
    step_tag = "random";
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        btn = 4'($urandom_range(0, 15));
        {left, right, up, down} = btn;
      end
      enable = ($urandom_range(0, 19) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
